// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the redun_mont squarer and its sequencer.
package redun_mont_pkg;

    localparam int NUM_WRDS    = 4;
    localparam int WRD_BITS    = 16;
    localparam int DAT_BITS    = NUM_WRDS * WRD_BITS;
    // Carry out of a single collapse step is at most 2.
    localparam int COLLAPSE_CW = 2;

    // Canonical field element.
    typedef logic [DAT_BITS-1:0] fe_t;

    // Redundant form: NUM_WRDS words of WRD_BITS+1 bits, word k weighted by 2^(k*WRD_BITS).
    typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

    // One-hot sequencer states.
    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_LOAD     = 5'b00010,
        S_RUN      = 5'b00100,
        S_COLLAPSE = 5'b01000,
        S_DONE     = 5'b10000
    } seq_state_t;

    // Canonical to redundant: every word gets a zero spare bit.
    function automatic redun0_t to_redun(input fe_t x);
        redun0_t r;
        for (int k = 0; k < NUM_WRDS; k++) begin
            r[k] = {1'b0, x[k*WRD_BITS +: WRD_BITS]};
        end
        return r;
    endfunction

endpackage

// File: rtl/redun_mont_seq_if.sv
// Host-side start/result handshake of the redun_mont sequencer.
interface redun_mont_seq_if #(
    parameter int ITER_W = 64
);
    import redun_mont_pkg::*;

    fe_t                    i_x;
    logic [ITER_W-1:0]      i_iters;
    logic                   i_start_val;
    logic                   o_start_rdy;
    logic                   i_abort;
    fe_t                    o_res;
    logic [COLLAPSE_CW-1:0] o_res_ovf;
    logic                   o_res_val;
    logic                   i_res_rdy;

    // Sequencer view.
    modport slave (
        input  i_x, i_iters, i_start_val, i_abort, i_res_rdy,
        output o_start_rdy, o_res, o_res_ovf, o_res_val
    );

    // Host view.
    modport master (
        output i_x, i_iters, i_start_val, i_abort, i_res_rdy,
        input  o_start_rdy, o_res, o_res_ovf, o_res_val
    );

endinterface

// File: rtl/redun_collapse.sv
// Word-serial carry resolver: turns a redundant value into canonical binary
// plus a small overflow, one word per cycle starting from word 0.
module redun_collapse
    import redun_mont_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_load,
    input  redun0_t                i_w,
    output fe_t                    o_res,
    output logic [COLLAPSE_CW-1:0] o_ovf,
    output logic                   o_last
);

    localparam int KW = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

    redun0_t                r_w;
    logic [KW-1:0]          r_k;
    logic                   r_busy;
    logic [COLLAPSE_CW-1:0] r_c;
    fe_t                    r_res;
    logic [COLLAPSE_CW-1:0] r_ovf;

    // A (WRD_BITS+1)-bit word plus a carry of at most 2 fits in WRD_BITS+2 bits.
    logic [WRD_BITS+1:0]    w_sum;

    assign w_sum  = {1'b0, r_w[r_k]} + {{WRD_BITS{1'b0}}, r_c};
    assign o_last = r_busy && (r_k == KW'(NUM_WRDS - 1));
    assign o_res  = r_res;
    assign o_ovf  = r_ovf;

    // Load a value, then resolve one word per cycle until the top word is done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the result registers are reset too, so a job killed by reset can never leave a stale value on o_res.
            r_w    <= '0;
            r_k    <= '0;
            r_busy <= 1'b0;
            r_c    <= '0;
            r_res  <= '0;
            r_ovf  <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_w    <= i_w;
            r_k    <= '0;
            r_busy <= 1'b1;
            r_c    <= '0;
            r_res  <= '0;
            r_ovf  <= '0;
        end else if (r_busy) begin
            // NOTE: non-blocking updates so w_sum is always formed from the pre-edge word index and carry.
            r_res[r_k*WRD_BITS +: WRD_BITS] <= w_sum[WRD_BITS-1:0];
            r_c                             <= w_sum[WRD_BITS +: COLLAPSE_CW];
            if (o_last) begin
                r_busy <= 1'b0;
                r_ovf  <= w_sum[WRD_BITS +: COLLAPSE_CW];
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/redun_mont_seq.sv
// Sequencer for the redun_mont repeated-squaring core: loads x, counts T
// squarings, collapses the final redundant result and hands it to the host.
module redun_mont_seq
    import redun_mont_pkg::*;
#(
    parameter int ITER_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    redun_mont_seq_if.slave   host_if,
    output redun0_t           o_sq,
    output logic              o_sq_val,
    output logic              o_sq_rst,
    input  redun0_t           i_mul,
    input  logic              i_mul_val,
    output logic [ITER_W-1:0] o_iter_cnt,
    output logic              o_busy
);

    seq_state_t        r_state;
    logic [ITER_W-1:0] r_iters;
    logic [ITER_W-1:0] r_iter_cnt;
    redun0_t           r_sq;
    logic              r_sq_val;
    logic              r_sq_rst;
    logic              r_res_val;

    logic              w_abort;
    logic              w_final;
    logic              w_coll_load;
    redun0_t           w_coll_w;
    logic              w_coll_last;

    // Abort only matters once a job is in flight; it beats every other event.
    assign w_abort = host_if.i_abort && (r_state != S_IDLE);

    // The squarer pulse that completes the T-th squaring.
    assign w_final = (r_state == S_RUN) && i_mul_val && (r_iter_cnt != r_iters) &&
                     ((r_iter_cnt + ITER_W'(1)) == r_iters);

    // The collapser is fed either x directly (T==0) or the final squarer result.
    assign w_coll_load = ((r_state == S_IDLE) && host_if.i_start_val && (host_if.i_iters == '0)) ||
                         (w_final && !host_if.i_abort);
    assign w_coll_w    = (r_state == S_IDLE) ? to_redun(host_if.i_x) : i_mul;

    redun_collapse u_collapse (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_abort),
        .i_load  (w_coll_load),
        .i_w     (w_coll_w),
        .o_res   (host_if.o_res),
        .o_ovf   (host_if.o_res_ovf),
        .o_last  (w_coll_last)
    );

    assign o_sq                = r_sq;
    assign o_sq_val            = r_sq_val;
    assign o_sq_rst            = r_sq_rst;
    assign o_iter_cnt          = r_iter_cnt;
    assign o_busy              = (r_state != S_IDLE);
    assign host_if.o_start_rdy = (r_state == S_IDLE);
    assign host_if.o_res_val   = r_res_val;

    // Job FSM with registered squarer handshake, iteration counter and result valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_iters    <= '0;
            r_iter_cnt <= '0;
            r_sq       <= '0;
            r_sq_val   <= 1'b0;
            r_sq_rst   <= 1'b1;
            r_res_val  <= 1'b0;
        end else begin
            r_sq_val <= 1'b0;
            if (w_abort) begin
                r_state   <= S_IDLE;
                r_sq_rst  <= 1'b1;
                r_res_val <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (host_if.i_start_val) begin
                            r_iters    <= host_if.i_iters;
                            r_iter_cnt <= '0;
                            if (host_if.i_iters == '0) begin
                                r_state <= S_COLLAPSE;
                            end else begin
                                // Squarer operand and load pulse are valid during LOAD.
                                r_state  <= S_LOAD;
                                r_sq     <= to_redun(host_if.i_x);
                                r_sq_val <= 1'b1;
                                r_sq_rst <= 1'b0;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (i_mul_val && (r_iter_cnt != r_iters)) begin
                            r_iter_cnt <= r_iter_cnt + ITER_W'(1);
                            if (w_final) begin
                                r_state  <= S_COLLAPSE;
                                r_sq_rst <= 1'b1;
                            end
                        end
                    end
                    S_COLLAPSE: begin
                        if (w_coll_last) begin
                            r_state   <= S_DONE;
                            r_res_val <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (host_if.i_res_rdy) begin
                            r_state   <= S_IDLE;
                            r_res_val <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_sq_rst  <= 1'b1;
                        r_res_val <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_redun_mont_seq.sv
// Directed self-checking bench for redun_mont_seq with a behavioural squarer
// and a scoreboard of expected canonical results.
module tb_redun_mont_seq;
    import redun_mont_pkg::*;

    localparam int ITER_W = 64;

    typedef struct {
        fe_t                    res;
        logic [COLLAPSE_CW-1:0] ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    redun0_t           sq;
    logic              sq_val;
    logic              sq_rst;
    redun0_t           mul;
    logic              mul_val;
    logic [ITER_W-1:0] iter_cnt;
    logic              busy;

    exp_t sb[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    int   n_sqv;
    logic saw;
    fe_t  v;
    redun0_t w;

    always #5 clk = ~clk;

    redun_mont_seq_if #(.ITER_W(ITER_W)) host_if ();

    redun_mont_seq #(.ITER_W(ITER_W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .host_if    (host_if),
        .o_sq       (sq),
        .o_sq_val   (sq_val),
        .o_sq_rst   (sq_rst),
        .i_mul      (mul),
        .i_mul_val  (mul_val),
        .o_iter_cnt (iter_cnt),
        .o_busy     (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Value of a redundant number, summed at full width.
    function automatic logic [DAT_BITS+1:0] full_sum(input redun0_t r);
        logic [DAT_BITS+1:0] acc;
        acc = '0;
        for (int k = 0; k < NUM_WRDS; k++) begin
            acc = acc + ({{(DAT_BITS+1-WRD_BITS){1'b0}}, r[k]} << (k*WRD_BITS));
        end
        return acc;
    endfunction

    function automatic redun0_t ref_redun(input fe_t x);
        redun0_t r;
        for (int k = 0; k < NUM_WRDS; k++) r[k] = {1'b0, x[k*WRD_BITS +: WRD_BITS]};
        return r;
    endfunction

    // Behavioural squarer: square mod 2^DAT_BITS, spare bit of each word set to word parity.
    function automatic redun0_t sq_model(input fe_t x);
        fe_t     p;
        redun0_t r;
        p = x * x;
        for (int k = 0; k < NUM_WRDS; k++) r[k] = {^p[k*WRD_BITS +: WRD_BITS], p[k*WRD_BITS +: WRD_BITS]};
        return r;
    endfunction

    task automatic push_exp(input redun0_t r);
        logic [DAT_BITS+1:0] s;
        exp_t e;
        s     = full_sum(r);
        e.res = s[DAT_BITS-1:0];
        e.ovf = s[DAT_BITS +: COLLAPSE_CW];
        sb.push_back(e);
    endtask

    task automatic start_job(input fe_t x, input logic [ITER_W-1:0] t);
        host_if.i_x         = x;
        host_if.i_iters     = t;
        host_if.i_start_val = 1'b1;
        tick();
        host_if.i_start_val = 1'b0;
    endtask

    // Advance until o_res_val or the budget runs out; lat counts cycles since the trigger.
    task automatic wait_res(input int budget, inout int l, inout logic s);
        while (!host_if.o_res_val && l < budget) begin
            s = s | sq_val;
            tick();
            l++;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        check({tag, "_val"}, host_if.o_res_val, 1);
        check({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            last_exp = e;
            check({tag, "_res"}, host_if.o_res, e.res);
            check({tag, "_ovf"}, host_if.o_res_ovf, e.ovf);
        end
    endtask

    task automatic accept();
        host_if.i_res_rdy = 1'b1;
        tick();
        host_if.i_res_rdy = 1'b0;
    endtask

    // Run n squarings through the model, pulsing i_mul_val every third cycle.
    task automatic run_squarings(input fe_t x, input int n, input string tag);
        fe_t cur;
        redun0_t r;
        cur = x;
        for (int i = 1; i <= n; i++) begin
            tick(2);
            r       = sq_model(cur);
            mul     = r;
            mul_val = 1'b1;
            if (i == n) push_exp(r);
            tick();
            mul_val = 1'b0;
            check($sformatf("%s_cnt%0d", tag, i), iter_cnt, i);
            check($sformatf("%s_sqrst%0d", tag, i), sq_rst, (i == n));
            cur = full_sum(r);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        host_if.i_x         = '0;
        host_if.i_iters     = '0;
        host_if.i_start_val = 1'b0;
        host_if.i_abort     = 1'b0;
        host_if.i_res_rdy   = 1'b0;
        mul                 = '0;
        mul_val             = 1'b0;
        tick(3);

        // Reset state.
        check("rst_start_rdy", host_if.o_start_rdy, 1);
        check("rst_busy", busy, 0);
        check("rst_sq_rst", sq_rst, 1);
        check("rst_sq_val", sq_val, 0);
        check("rst_sq", sq, 0);
        check("rst_res_val", host_if.o_res_val, 0);
        check("rst_res", host_if.o_res, 0);
        check("rst_iter_cnt", iter_cnt, 0);
        rst = 1'b0;
        tick();

        // 1) T=0: result is x itself, no squarer activity.
        last_exp.res = 64'h1234;
        last_exp.ovf = 2'd0;
        sb.push_back(last_exp);
        start_job(64'h1234, 0);
        check("t1_busy", busy, 1);
        check("t1_start_rdy", host_if.o_start_rdy, 0);
        lat = 1;
        saw = 1'b0;
        wait_res(20, lat, saw);
        check("t1_latency", lat, NUM_WRDS + 1);
        check("t1_no_sq_val", saw, 0);
        check_result("t1");
        check("t1_iter_cnt", iter_cnt, 0);
        accept();
        check("t1_res_val_drop", host_if.o_res_val, 0);
        check("t1_idle_rdy", host_if.o_start_rdy, 1);

        // 2) T=5 with the behavioural squarer.
        v = 64'h0123_4567_89AB_CDEF;
        start_job(v, 5);
        check("t2_sq_val", sq_val, 1);
        check("t2_sq", sq, ref_redun(v));
        check("t2_sq_rst_low", sq_rst, 0);
        n_sqv = 1;
        tick();
        check("t2_sq_val_pulse", sq_val, 0);
        run_squarings(v, 5, "t2");
        lat = 1;
        saw = 1'b0;
        wait_res(20, lat, saw);
        check("t2_latency", lat, NUM_WRDS + 1);
        check("t2_sq_val_count", n_sqv + int'(saw), 1);
        check_result("t2");
        check("t2_sq_held", sq, ref_redun(v));
        accept();

        // 3) Every redundant word at its maximum: worst-case carries.
        start_job(64'h55, 1);
        tick();
        for (int k = 0; k < NUM_WRDS; k++) w[k] = '1;
        mul     = w;
        mul_val = 1'b1;
        push_exp(w);
        tick();
        mul_val = 1'b0;
        lat = 1;
        saw = 1'b0;
        wait_res(20, lat, saw);
        check("t3_latency", lat, NUM_WRDS + 1);
        check_result("t3");
        check("t3_ovf_le2", host_if.o_res_ovf <= 2'd2, 1);

        // 4) Hold the result for 10 cycles; a start and a squarer pulse in DONE are ignored.
        for (int c = 0; c < 10; c++) begin
            host_if.i_start_val = (c == 3);
            host_if.i_x         = 64'hFFFF;
            host_if.i_iters     = '0;
            mul_val             = (c == 5);
            tick();
            check($sformatf("t4_val%0d", c), host_if.o_res_val, 1);
            check($sformatf("t4_res%0d", c), host_if.o_res, last_exp.res);
            check($sformatf("t4_ovf%0d", c), host_if.o_res_ovf, last_exp.ovf);
        end
        host_if.i_start_val = 1'b0;
        mul_val             = 1'b0;
        check("t4_iter_cnt", iter_cnt, 1);
        check("t4_start_rdy_done", host_if.o_start_rdy, 0);
        accept();
        check("t4_res_val_drop", host_if.o_res_val, 0);
        check("t4_start_rdy", host_if.o_start_rdy, 1);
        tick(6);
        check("t4_no_ghost_job", busy, 0);

        // 5) Abort coincident with the third squarer pulse of T=8.
        v = 64'hDEAD_BEEF_0000_1111;
        start_job(v, 8);
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick(2);
            mul             = sq_model(v);
            mul_val         = 1'b1;
            host_if.i_abort = (i == 3);
            tick();
            mul_val         = 1'b0;
            host_if.i_abort = 1'b0;
            if (i < 3) check($sformatf("t5_cnt%0d", i), iter_cnt, i);
            v = full_sum(mul);
        end
        check("t5_busy", busy, 0);
        check("t5_start_rdy", host_if.o_start_rdy, 1);
        check("t5_sq_rst", sq_rst, 1);
        check("t5_res_val", host_if.o_res_val, 0);
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            saw = saw | host_if.o_res_val;
            tick();
        end
        check("t5_no_result", saw, 0);
        check("t5_sb_empty", sb.size(), 0);
        v = 64'h42;
        start_job(v, 2);
        check("t5b_sq_val", sq_val, 1);
        check("t5b_sq", sq, ref_redun(v));
        tick();
        run_squarings(v, 2, "t5b");
        lat = 1;
        saw = 1'b0;
        wait_res(20, lat, saw);
        check("t5b_latency", lat, NUM_WRDS + 1);
        check_result("t5b");
        accept();

        // 6) Reset in the middle of COLLAPSE.
        push_exp(ref_redun(64'hABCD_EF01_2345_6789));
        start_job(64'hABCD_EF01_2345_6789, 0);
        tick();
        rst = 1'b1;
        tick();
        sb.delete();
        check("t6_start_rdy", host_if.o_start_rdy, 1);
        check("t6_busy", busy, 0);
        check("t6_sq_rst", sq_rst, 1);
        check("t6_sq_val", sq_val, 0);
        check("t6_sq", sq, 0);
        check("t6_res_val", host_if.o_res_val, 0);
        check("t6_res", host_if.o_res, 0);
        check("t6_ovf", host_if.o_res_ovf, 0);
        check("t6_iter_cnt", iter_cnt, 0);
        rst = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            saw = saw | host_if.o_res_val;
            tick();
        end
        check("t6_no_stale", saw, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
